// File: rtl/sound_unpacker_if.sv
// ----------------------------------------------------------------------------
// sound_unpacker_if
//
// Groups the two streaming sides of the sound unpacker:
//   - payload byte stream : byte_data, byte_valid (into the unpacker),
//                           byte_ready (out of the unpacker)
//   - sample write port   : sound_write, sound_l, sound_r (out of the unpacker),
//                           sound_write_ready (into the unpacker)
//
// Modports:
//   master - the unpacker itself (drives byte_ready and the sample write port)
//   slave  - its environment (byte source plus the sound stage write port)
// ----------------------------------------------------------------------------
interface sound_unpacker_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        sound_write_ready;
    logic        sound_write;
    logic [15:0] sound_l;
    logic [15:0] sound_r;

    modport master (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        input  sound_write_ready,
        output sound_write,
        output sound_l,
        output sound_r
    );

    modport slave (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        output sound_write_ready,
        input  sound_write,
        input  sound_l,
        input  sound_r
    );
endinterface

// File: rtl/sound_unpacker.sv
// ----------------------------------------------------------------------------
// sound_unpacker
//
// Turns one audio payload (a byte stream of audio_bytes bytes) into 16-bit
// little-endian PCM sample pairs and offers them, one per handshake, to the
// sound FIFO stage write port. Trailing bytes that cannot form a full sample
// (and every byte of a muted payload) are consumed and dropped. audio_done
// pulses once the whole payload has been consumed.
//
// Ports:
//   clk_sys          system clock, everything is synchronous to it
//   sound_reset      synchronous active-high reset
//   sound_chan       0 muted, 1 mono, 2/3 stereo (latched at audio_start)
//   audio_start      one-cycle pulse starting a payload
//   audio_bytes      payload length in bytes (latched at audio_start)
//   sound_atten      right-shift attenuation (only with SOUND_ATTEN_EN)
//   bus              byte stream in / sample write port out (master modport)
//   busy             payload in progress
//   audio_done       one-cycle completion pulse
//   samples_written  running count of issued sample writes (wraps)
//
// Build option:
//   SOUND_ATTEN_EN   when defined, adds sound_atten[2:0]; each sample is
//                    arithmetically shifted right by it before output.
// ----------------------------------------------------------------------------
module sound_unpacker #(
    parameter int CNT_W = 32
) (
    input  logic             clk_sys,
    input  logic             sound_reset,
    input  logic [1:0]       sound_chan,
    input  logic             audio_start,
    input  logic [CNT_W-1:0] audio_bytes,
`ifdef SOUND_ATTEN_EN
    input  logic [2:0]       sound_atten,
`endif
    sound_unpacker_if.master bus,
    output logic             busy,
    output logic             audio_done,
    output logic [CNT_W-1:0] samples_written
);

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        L_LO,
        L_HI,
        R_LO,
        R_HI,
        WRITE,
        DISCARD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bytes_left_q, bytes_left_d;
    logic [1:0]       chan_q, chan_d;
    logic [7:0]       l_lo_q, l_lo_d;
    logic [7:0]       r_lo_q, r_lo_d;
    logic [15:0]      l_full_q, l_full_d;
    logic [15:0]      sound_l_q, sound_l_d;
    logic [15:0]      sound_r_q, sound_r_d;
    logic [CNT_W-1:0] samples_written_q, samples_written_d;
    logic             byte_ready_q, byte_ready_d;
    logic             busy_q, busy_d;
    logic             audio_done_q, audio_done_d;
`ifdef SOUND_ATTEN_EN
    logic [2:0]       atten_q, atten_d;
`endif

    logic byte_take;
    logic write_fire;

    assign byte_take  = bus.byte_valid && byte_ready_q;
    assign write_fire = (state_q == WRITE) && bus.sound_write_ready;

    // Sample-boundary decision: finish, drop the rest, or start a new sample.
    function automatic state_t boundary(input logic [CNT_W-1:0] left,
                                        input logic [1:0]       chan);
        if (left == '0) begin
            return DONE;
        end
        if (chan == 2'd0) begin
            return DISCARD;
        end
        if (left < (chan[1] ? CNT_W'(4) : CNT_W'(2))) begin
            return DISCARD;
        end
        return L_LO;
    endfunction

    function automatic logic [15:0] scale(input logic [15:0] s);
`ifdef SOUND_ATTEN_EN
        return $signed(s) >>> atten_q;
`else
        return s;
`endif
    endfunction

    always_comb begin
        state_d           = state_q;
        bytes_left_d      = bytes_left_q;
        chan_d            = chan_q;
        l_lo_d            = l_lo_q;
        r_lo_d            = r_lo_q;
        l_full_d          = l_full_q;
        sound_l_d         = sound_l_q;
        sound_r_d         = sound_r_q;
        samples_written_d = samples_written_q;
`ifdef SOUND_ATTEN_EN
        atten_d           = atten_q;
`endif

        if (byte_take) begin
            bytes_left_d = bytes_left_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (audio_start) begin
                    chan_d       = sound_chan;
                    bytes_left_d = audio_bytes;
`ifdef SOUND_ATTEN_EN
                    atten_d      = sound_atten;
`endif
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                state_d = boundary(bytes_left_q, chan_q);
            end
            L_LO: begin
                if (byte_take) begin
                    l_lo_d  = bus.byte_data;
                    state_d = L_HI;
                end
            end
            L_HI: begin
                if (byte_take) begin
                    if (chan_q[1]) begin
                        // Hold the left half until the right half arrives so
                        // the output pair only changes when it is complete.
                        l_full_d = {bus.byte_data, l_lo_q};
                        state_d  = R_LO;
                    end else begin
                        sound_l_d = scale({bus.byte_data, l_lo_q});
                        sound_r_d = scale({bus.byte_data, l_lo_q});
                        state_d   = WRITE;
                    end
                end
            end
            R_LO: begin
                if (byte_take) begin
                    r_lo_d  = bus.byte_data;
                    state_d = R_HI;
                end
            end
            R_HI: begin
                if (byte_take) begin
                    sound_l_d = scale(l_full_q);
                    sound_r_d = scale({bus.byte_data, r_lo_q});
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // The boundary decision is taken straight out of WRITE so a
                // new sample starts on the next cycle: 3 cycles per mono and
                // 5 per stereo sample. CHECK as a state is only visited at
                // payload start.
                if (write_fire) begin
                    samples_written_d = samples_written_q + CNT_W'(1);
                    state_d           = boundary(bytes_left_q, chan_q);
                end
            end
            DISCARD: begin
                if (bytes_left_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        byte_ready_d = (state_d inside {L_LO, L_HI, R_LO, R_HI}) ||
                       ((state_d == DISCARD) && (bytes_left_d != '0));
        busy_d       = !(state_d inside {IDLE, DONE});
        audio_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_sys) begin
        if (sound_reset) begin
            state_q           <= IDLE;
            bytes_left_q      <= '0;
            chan_q            <= '0;
            l_lo_q            <= '0;
            r_lo_q            <= '0;
            l_full_q          <= '0;
            sound_l_q         <= '0;
            sound_r_q         <= '0;
            samples_written_q <= '0;
            byte_ready_q      <= 1'b0;
            busy_q            <= 1'b0;
            audio_done_q      <= 1'b0;
`ifdef SOUND_ATTEN_EN
            atten_q           <= '0;
`endif
        end else begin
            state_q           <= state_d;
            bytes_left_q      <= bytes_left_d;
            chan_q            <= chan_d;
            l_lo_q            <= l_lo_d;
            r_lo_q            <= r_lo_d;
            l_full_q          <= l_full_d;
            sound_l_q         <= sound_l_d;
            sound_r_q         <= sound_r_d;
            samples_written_q <= samples_written_d;
            byte_ready_q      <= byte_ready_d;
            busy_q            <= busy_d;
            audio_done_q      <= audio_done_d;
`ifdef SOUND_ATTEN_EN
            atten_q           <= atten_d;
`endif
        end
    end

    assign bus.byte_ready  = byte_ready_q;
    assign bus.sound_write = write_fire;
    assign bus.sound_l     = sound_l_q;
    assign bus.sound_r     = sound_r_q;
    assign busy            = busy_q;
    assign audio_done      = audio_done_q;
    assign samples_written = samples_written_q;

endmodule

// File: doc/sound_unpacker.md
Name: sound_unpacker

Overview:
- Upstream feeder of the sound FIFO stage. Consumes the audio payload byte stream from the network/DDR fetch path (one payload per audio block command).
- Assembles little-endian 16-bit PCM samples according to the channel mode.
- Presents one sample pair per write handshake on sound_write / sound_write_ready, which connect to the sound stage's write port.
- Tracks payload length, discards trailing partial samples, and signals block completion.

Parameters:
- CNT_W, 32, width of payload byte counter and samples_written counter.

Ports:
- clk_sys  in  1  system clock; all logic is on this clock.
- sound_reset  in  1  synchronous, active-high reset.
- sound_chan  in  2  0=muted (discard payload), 1=mono, 2 or 3=stereo; sampled at audio_start.
- audio_start  in  1  one-cycle pulse: a new payload begins.
- audio_bytes  in  CNT_W  payload length in bytes; sampled with audio_start.
- byte_data  in  8  payload byte.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  unpacker accepts a byte this cycle.
- sound_write_ready  in  1  downstream can take a sample.
- sound_write  out  1  sample-pair write strobe.
- sound_l  out  16  left sample.
- sound_r  out  16  right sample.
- busy  out  1  payload in progress.
- audio_done  out  1  one-cycle pulse when the payload is fully consumed.
- samples_written  out  CNT_W  running count of issued writes.

Behaviour:
- Reset state:
  - FSM is IDLE.
  - All outputs are 0: byte_ready, sound_write, sound_l, sound_r, busy, audio_done, samples_written.
  - The internal bytes_left counter and the latched channel mode are 0.
- Reset mid-payload aborts immediately. No write and no done pulse are issued, and the partial sample is dropped.
- Byte acceptance: a byte is accepted when byte_valid && byte_ready. byte_ready is high only in L_LO, L_HI, R_LO, R_HI and DISCARD with bytes_left>0. Each accepted byte decrements bytes_left.
- States:
  - IDLE: on audio_start, latch chan and bytes_left=audio_bytes, then go to CHECK. busy=1 from the next cycle. audio_start in any other state is ignored.
  - CHECK (sample boundary):
    - bytes_left==0 -> DONE.
    - chan==0 -> DISCARD.
    - Otherwise, if bytes_left < bytes_per_sample (2 mono, 4 stereo) -> DISCARD.
    - Otherwise -> L_LO.
  - L_LO: accept byte into l[7:0], then L_HI.
  - L_HI: accept byte into l[15:8]. Stereo -> R_LO. Mono -> WRITE, with r=l.
  - R_LO, R_HI: accept bytes into r[7:0] and r[15:8]. R_HI -> WRITE.
  - WRITE:
    - sound_write = (state==WRITE) && sound_write_ready (combinational).
    - In the cycle sound_write=1: increment samples_written (wraps modulo 2^CNT_W), then go to CHECK.
    - sound_l/sound_r are registered, update only when the sample completes, and stay stable throughout WRITE.
  - DISCARD: accept and drop bytes until bytes_left==0, then DONE.
  - DONE: audio_done=1 for one cycle, busy=0, return to IDLE.
- Timing and handshake:
  - Latency: final byte of a sample accepted in cycle N -> sound_write can be high in cycle N+1.
  - sound_write is never high for two consecutive cycles. This is required because downstream registers its FIFO write request.
- Throughput: one sample per 3 cycles (mono) or 5 cycles (stereo) with continuous valid/ready.
- Backpressure: while in WRITE with sound_write_ready=0, byte_ready=0 and the state holds indefinitely.
- byte_valid low while collecting a sample: the state holds and partial bytes are retained.
- Zero-length payload: IDLE -> CHECK -> DONE, so audio_done pulses 2 cycles after audio_start with no writes.

Optional Feature:
- Macro: SOUND_ATTEN_EN.
- Defined: adds input port sound_atten [2:0], sampled at audio_start.
  - Each assembled sample is arithmetically right-shifted (sign-preserving) by sound_atten before being registered onto sound_l/sound_r.
  - Mono duplicates the shifted value to r.
  - Latency is unchanged.
- Undefined: the port is absent and samples pass unmodified.

Test Plan:
- Stereo, audio_bytes=8, bytes 34 12 78 56 CD AB 01 EF, ready held high:
  - Two writes: (L=0x1234, R=0x5678) then (L=0xABCD, R=0xEF01).
  - samples_written=2; audio_done pulses once; at most one write per 5 cycles.
- Mono, audio_bytes=5, bytes 00 80 FF 7F 11:
  - Writes (0x8000, 0x8000) and (0x7FFF, 0x7FFF).
  - Byte 0x11 is discarded, then audio_done pulses.
- sound_chan=0, audio_bytes=6: all 6 bytes accepted, no sound_write, audio_done pulses after the 6th byte.
- Stereo, sound_write_ready low for 20 cycles when the first sample completes:
  - sound_write=0 and byte_ready=0 throughout; sound_l/sound_r stable.
  - Single write on the cycle ready rises.
- Reset asserted after 3 bytes of a stereo sample:
  - All outputs 0 the next cycle, no write, no audio_done.
  - A new audio_start then behaves normally.
- With SOUND_ATTEN_EN, sound_atten=2, mono sample 0x8000: write value 0xE000.
